// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the register file write port. Each source has a one-entry buffer, and the buffers drain into registered write outputs.
// Contested grants alternate between the sources; define REGARB_FIXED_PRIORITY_EN to always favour source A instead.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Valid,
  output logic              A_Ready,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_Data,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_Data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              Idle
);

  // Register 0 is hard-wired; writes to it are consumed but never enabled.
  function automatic logic write_enable(input logic [ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

  logic              buf_a_vld_p0, buf_b_vld_p0;
  logic [ADDR_W-1:0] buf_a_addr_p0, buf_b_addr_p0;
  logic [DATA_W-1:0] buf_a_data_p0, buf_b_data_p0;
  logic              grant_a, grant_b;
  logic              accept_a, accept_b;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

`ifdef REGARB_FIXED_PRIORITY_EN
  assign grant_a = buf_a_vld_p0;
  assign grant_b = buf_b_vld_p0 && !buf_a_vld_p0;
`else
  logic rr_b;  // set when B wins the next contested grant

  assign grant_a = buf_a_vld_p0 && (!buf_b_vld_p0 || !rr_b);
  assign grant_b = buf_b_vld_p0 && (!buf_a_vld_p0 || rr_b);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_b <= 1'b0;
    end else if (buf_a_vld_p0 && buf_b_vld_p0) begin
      rr_b <= !rr_b;
    end
  end
`endif

  assign A_Ready  = !buf_a_vld_p0 || grant_a;
  assign B_Ready  = !buf_b_vld_p0 || grant_b;
  assign accept_a = A_Valid && A_Ready;
  assign accept_b = B_Valid && B_Ready;

  assign grant_addr = grant_a ? buf_a_addr_p0 : buf_b_addr_p0;
  assign grant_data = grant_a ? buf_a_data_p0 : buf_b_data_p0;

  // Stage p0: holding buffers (valid bits are control; payload needs no reset)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      buf_a_vld_p0 <= 1'b0;
      buf_b_vld_p0 <= 1'b0;
    end else begin
      if (accept_a)     buf_a_vld_p0 <= 1'b1;
      else if (grant_a) buf_a_vld_p0 <= 1'b0;
      if (accept_b)     buf_b_vld_p0 <= 1'b1;
      else if (grant_b) buf_b_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept_a) begin
      buf_a_addr_p0 <= A_Addr;
      buf_a_data_p0 <= A_Data;
    end
    if (accept_b) begin
      buf_b_addr_p0 <= B_Addr;
      buf_b_data_p0 <= B_Data;
    end
  end

  // Stage p1: registered write port into the register file
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (grant_a || grant_b) begin
      RegWrite      <= write_enable(grant_addr);
      WriteRegister <= grant_addr;
      WriteData     <= grant_data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  assign Idle = !buf_a_vld_p0 && !buf_b_vld_p0 && !RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              A_Valid = 1'b0, B_Valid = 1'b0;
  logic              A_Ready, B_Ready;
  logic [ADDR_W-1:0] A_Addr = '0, B_Addr = '0;
  logic [DATA_W-1:0] A_Data = '0, B_Data = '0;
  logic              RegWrite, Idle;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Addr(A_Addr), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Addr(B_Addr), .B_Data(B_Data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Idle(Idle)
  );

  // Register file driven by the DUT's write port
  logic [DATA_W-1:0] dut_rf [32] = '{default: '0};
  always @(posedge Clk) if (RegWrite) dut_rf[WriteRegister] <= WriteData;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each source is a queue of capacity one
  req_t qa[$];
  req_t qb[$];
`ifndef REGARB_FIXED_PRIORITY_EN
  bit turn_b;
`endif
  bit                exp_we;
  logic [ADDR_W-1:0] exp_wr;
  logic [DATA_W-1:0] exp_wd;
  bit                acc_a, acc_b;

  function automatic int winner();  // 0 none, 1 A, 2 B
    if (qa.size() != 0 && qb.size() != 0) begin
`ifdef REGARB_FIXED_PRIORITY_EN
      return 1;
`else
      return turn_b ? 2 : 1;
`endif
    end
    if (qa.size() != 0) return 1;
    if (qb.size() != 0) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
`ifndef REGARB_FIXED_PRIORITY_EN
    turn_b = 1'b0;
`endif
    exp_we = 1'b0;
    exp_wr = '0;
    exp_wd = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int w = winner();
    chk("RegWrite", RegWrite, exp_we);
    chk("WriteRegister", WriteRegister, exp_wr);
    chk("WriteData", WriteData, exp_wd);
    chk("Idle", Idle, qa.size() == 0 && qb.size() == 0 && !exp_we);
    chk("A_Ready", A_Ready, qa.size() == 0 || w == 1);
    chk("B_Ready", B_Ready, qb.size() == 0 || w == 2);
  endtask

  // Called at a negedge: drive inputs, advance the model across the next posedge, check at the following negedge.
  task automatic tick(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    int   w;
    bit   ra, rb;
    req_t r;
    A_Valid = av; A_Addr = aa; A_Data = ad;
    B_Valid = bv; B_Addr = ba; B_Data = bd;
    w  = winner();
    ra = (qa.size() == 0) || (w == 1);
    rb = (qb.size() == 0) || (w == 2);
`ifndef REGARB_FIXED_PRIORITY_EN
    if (qa.size() != 0 && qb.size() != 0) turn_b = !turn_b;
`endif
    if (w == 1) r = qa.pop_front();
    else if (w == 2) r = qb.pop_front();
    if (w != 0) begin
      exp_we = (r.addr != 0);
      exp_wr = r.addr;
      exp_wd = r.data;
    end else begin
      exp_we = 1'b0;
    end
    acc_a = av && ra;
    acc_b = bv && rb;
    if (acc_a) begin r.addr = aa; r.data = ad; qa.push_back(r); end
    if (acc_b) begin r.addr = ba; r.data = bd; qb.push_back(r); end
    @(negedge Clk);
    check_all();
  endtask

  task automatic idle_tick();
    tick(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [ADDR_W-1:0] rec [4];
    int                nrec;
    bit                pa, pb;
    bit                va, vb;
    logic [ADDR_W-1:0] xa, xb;
    logic [DATA_W-1:0] da, db;
    int                ka, kb;

    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    chk("rst_Idle", Idle, 1);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_WriteData", WriteData, 0);
    Reset = 1'b0;

    // Single uncontested write
    tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    idle_tick();
    chk("single_we", RegWrite, 1);
    chk("single_wr", WriteRegister, 5);
    chk("single_wd", WriteData, 32'hDEADBEEF);
    idle_tick();
    chk("single_idle", Idle, 1);

    // Contested pairs: the pointer alternates between them
    tick(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222);
    idle_tick();
    chk("pair1_first", WriteRegister, 3);
    idle_tick();
    chk("pair1_second", WriteRegister, 4);
    tick(1'b1, 5'd10, 32'h10101010, 1'b1, 5'd11, 32'h11011011);
    idle_tick();
`ifdef REGARB_FIXED_PRIORITY_EN
    chk("pair2_first", WriteRegister, 10);
`else
    chk("pair2_first", WriteRegister, 11);
`endif
    idle_tick();

    // Same address from both sources: the later grant's data is final
    tick(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h0000BBBB);
    idle_tick();
    chk("same_first", WriteData, 32'hAAAA0000);
    idle_tick();
    chk("same_second", WriteData, 32'h0000BBBB);
    idle_tick();
    chk("r7_final", dut_rf[7], 32'h0000BBBB);

    // Address 0 is consumed without a write pulse
    chk("b0_ready", B_Ready, 1);
    tick(1'b0, '0, '0, 1'b1, 5'd0, 32'h12345678);
    idle_tick();
    chk("b0_no_we", RegWrite, 0);
    idle_tick();
    chk("r0_zero", dut_rf[0], 0);

    // A saturated for 8 writes
    for (int i = 0; i < 8; i++) begin
      chk("a_sat_ready", A_Ready, 1);
      tick(1'b1, 5'(i + 1), 32'hA0 + i, 1'b0, '0, '0);
      if (i > 0) begin
        chk("a_sat_we", RegWrite, 1);
        chk("a_sat_wr", WriteRegister, i);
      end
    end
    idle_tick();
    chk("a_sat_last", WriteRegister, 8);
    idle_tick();

    // Reset between accept and grant
    tick(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, '0, '0);
    #1;
    Reset = 1'b1;
    A_Valid = 1'b0;
    #1;
    chk("mid_rst_ready", A_Ready, 1);
    chk("mid_rst_idle", Idle, 1);
    chk("mid_rst_we", RegWrite, 0);
    model_reset();
    @(negedge Clk);
    check_all();
    Reset = 1'b0;
    repeat (3) idle_tick();
    chk("r9_unchanged", dut_rf[9], 0);

    // Both sources saturated; requests held while not ready
    nrec = 0; pa = 0; pb = 0; ka = 0; kb = 0;
    xa = '0; xb = '0; da = '0; db = '0;
    for (int c = 0; c < 12; c++) begin
      if (!pa) begin xa = 5'(16 + ka); da = 32'hA000 + ka; ka++; end
      if (!pb) begin xb = 5'(24 + kb); db = 32'hB000 + kb; kb++; end
      tick(1'b1, xa, da, 1'b1, xb, db);
      pa = !acc_a;
      pb = !acc_b;
      if (RegWrite && nrec < 4) begin rec[nrec] = WriteRegister; nrec++; end
    end
    repeat (3) idle_tick();
    chk("sat_count", nrec, 4);
`ifdef REGARB_FIXED_PRIORITY_EN
    chk("sat_g0", rec[0], 16); chk("sat_g1", rec[1], 17);
    chk("sat_g2", rec[2], 18); chk("sat_g3", rec[3], 19);
`else
    chk("sat_g0", rec[0], 16); chk("sat_g1", rec[1], 24);
    chk("sat_g2", rec[2], 17); chk("sat_g3", rec[3], 25);
`endif

    // Random traffic with hold-while-not-ready sources
    pa = 0; pb = 0; va = 0; vb = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pa) begin
        va = ($urandom_range(0, 9) < 6);
        xa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        da = $urandom;
      end
      if (!pb) begin
        vb = ($urandom_range(0, 9) < 5);
        xb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        db = $urandom;
      end
      tick(va, xa, da, vb, xb, db);
      pa = va && !acc_a;
      pb = vb && !acc_b;
    end
    repeat (3) idle_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
